// File: rtl/mdu_pkg.sv
// Shared multiply/divide unit definitions: opcode encodings, controller states and
// default latencies. Also used by the MDU datapath itself.
package mdu_pkg;

    localparam logic [2:0] MDU_NONE  = 3'd0;
    localparam logic [2:0] MDU_MULT  = 3'd1;
    localparam logic [2:0] MDU_MULTU = 3'd2;
    localparam logic [2:0] MDU_DIV   = 3'd3;
    localparam logic [2:0] MDU_DIVU  = 3'd4;
    localparam logic [2:0] MDU_MTLO  = 3'd5;
    localparam logic [2:0] MDU_MTHI  = 3'd6;
    localparam logic [2:0] MDU_RSVD  = 3'd7;

    localparam int MDU_MUL_LAT_DEF = 5;
    localparam int MDU_DIV_LAT_DEF = 10;
    localparam int MDU_CNT_W       = 6;

    typedef enum logic [1:0] {
        MDU_IDLE     = 2'd0,
        MDU_MUL_BUSY = 2'd1,
        MDU_DIV_BUSY = 2'd2
    } mdu_state_e;

    function automatic logic mdu_is_mul(input logic [2:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic mdu_is_div(input logic [2:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    // Any opcode that touches HI/LO and therefore must wait for an in-flight op.
    function automatic logic mdu_is_hilo(input logic [2:0] op);
        return (op != MDU_NONE) && (op != MDU_RSVD);
    endfunction

endpackage

// File: rtl/mdu_lat_cnt.sv
// Loadable 6-bit down-counter tracking the MDU busy window; done flags the final busy cycle.
module mdu_lat_cnt
    import mdu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load_i,
    input  logic [MDU_CNT_W-1:0] load_val_i,
    output logic [MDU_CNT_W-1:0] cnt_o,
    output logic                 done_o
);

    logic [MDU_CNT_W-1:0] cnt_q;
    logic [MDU_CNT_W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o  = cnt_q;
    assign done_o = (cnt_q == MDU_CNT_W'(1));

endmodule

// File: rtl/mdu_ctrl.sv
// EX-stage issue/hazard controller for the multiply/divide unit.
// Optional build macro MDU_CTRL_STALL_CNT_EN adds a free-running stall cycle counter.
module mdu_ctrl
    import mdu_pkg::*;
#(
    parameter int MUL_LAT = MDU_MUL_LAT_DEF,
    parameter int DIV_LAT = MDU_DIV_LAT_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 issue_valid,
    input  logic [2:0]           issue_op,
    input  logic                 issue_mf,
    input  logic                 flush,
    output logic                 mdu_start,
    output logic [2:0]           mdu_op,
    output logic                 stall,
    output logic                 busy,
`ifdef MDU_CTRL_STALL_CNT_EN
    output logic [31:0]          stall_cnt,
`endif
    output mdu_state_e           dbg_state,
    output logic [MDU_CNT_W-1:0] dbg_cnt
);

    // Handshake: an EX request is accepted (go) in a cycle with issue_valid high, flush low
    // and stall low; while stall is high the pipeline holds the request and re-presents it.

    mdu_state_e           state_q;
    logic                 req;
    logic                 go;
    logic                 op_fwd;
    logic                 cnt_load;
    logic [MDU_CNT_W-1:0] cnt_load_val;
    logic [MDU_CNT_W-1:0] cnt;
    logic                 cnt_done;

    assign busy   = (state_q != MDU_IDLE);
    assign req    = issue_valid && (mdu_is_hilo(issue_op) || issue_mf);
    assign stall  = busy && req;
    assign go     = issue_valid && !flush && !stall;
    assign op_fwd = go && mdu_is_hilo(issue_op);

    assign mdu_op    = op_fwd ? issue_op : MDU_NONE;
    assign mdu_start = go && (mdu_is_mul(issue_op) || mdu_is_div(issue_op));

    // A start can only occur in IDLE since any start opcode stalls while busy.
    assign cnt_load     = mdu_start;
    assign cnt_load_val = mdu_is_mul(issue_op) ? MDU_CNT_W'(MUL_LAT) : MDU_CNT_W'(DIV_LAT);

    mdu_lat_cnt u_lat_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .cnt_o      (cnt),
        .done_o     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= MDU_IDLE;
        end else begin
            case (state_q)
                MDU_IDLE: begin
                    if (mdu_start) begin
                        state_q <= mdu_is_mul(issue_op) ? MDU_MUL_BUSY : MDU_DIV_BUSY;
                    end
                end
                MDU_MUL_BUSY, MDU_DIV_BUSY: begin
                    if (cnt_done) begin
                        state_q <= MDU_IDLE;
                    end
                end
                default: state_q <= MDU_IDLE;
            endcase
        end
    end

`ifdef MDU_CTRL_STALL_CNT_EN
    logic [31:0] stall_cnt_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else if (stall) begin
            stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

    assign dbg_state = state_q;
    assign dbg_cnt   = cnt;

endmodule

// File: tb/tb_mdu_ctrl.sv
// Self-checking bench for mdu_ctrl: directed hazard sequences followed by random traffic,
// checked against an independent cycle model through an expected-value queue.
module tb_mdu_ctrl;
  import mdu_pkg::*;

  localparam int MUL_LAT = 5;
  localparam int DIV_LAT = 10;
  localparam int W = 12;

  logic       clk;
  logic       rst_n;
  logic       issue_valid;
  logic [2:0] issue_op;
  logic       issue_mf;
  logic       flush;
  logic       mdu_start;
  logic [2:0] mdu_op;
  logic       stall;
  logic       busy;
  mdu_state_e dbg_state;
  logic [5:0] dbg_cnt;
`ifdef MDU_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt;
  logic [31:0] m_stall_cnt;
`endif

  int n_checks;
  int n_errors;
  logic [W-1:0] exp_q[$];

  // model state: remaining busy cycles and kind of op in flight
  int m_cnt;
  int m_kind; // 0 idle, 1 mul, 2 div

  mdu_ctrl #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .issue_valid (issue_valid),
    .issue_op    (issue_op),
    .issue_mf    (issue_mf),
    .flush       (flush),
    .mdu_start   (mdu_start),
    .mdu_op      (mdu_op),
    .stall       (stall),
    .busy        (busy),
`ifdef MDU_CTRL_STALL_CNT_EN
    .stall_cnt   (stall_cnt),
`endif
    .dbg_state   (dbg_state),
    .dbg_cnt     (dbg_cnt)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Drive one cycle, predict outputs, compare them, then advance the model at the edge.
  task automatic step(input logic v, input logic [2:0] op, input logic mf,
                      input logic fl, input logic rn);
    logic e_busy, e_req, e_stall, e_go, e_start;
    logic [2:0] e_op;
    logic [1:0] e_state;
    logic [W-1:0] got;
    @(negedge clk);
    rst_n = rn; issue_valid = v; issue_op = op; issue_mf = mf; flush = fl;
    e_busy  = (m_cnt > 0);
    e_req   = v && (((op >= 3'd1) && (op <= 3'd6)) || mf);
    e_stall = e_busy && e_req;
    e_go    = v && !fl && !e_stall;
    e_op    = (e_go && op != 3'd7) ? op : 3'd0;
    e_start = e_go && (op >= 3'd1) && (op <= 3'd4);
    e_state = 2'(m_kind);
    exp_q.push_back({e_start, e_op, e_stall, e_busy, 6'(m_cnt)});
    #1;
    got = exp_q.pop_front();
    check("start", 32'(mdu_start), 32'(got[11]));
    check("op",    32'(mdu_op),    32'(got[10:8]));
    check("stall", 32'(stall),     32'(got[7]));
    check("busy",  32'(busy),      32'(got[6]));
    check("cnt",   32'(dbg_cnt),   32'(got[5:0]));
    check("state", 32'(dbg_state), 32'(e_state));
`ifdef MDU_CTRL_STALL_CNT_EN
    check("stall_cnt", stall_cnt, m_stall_cnt);
`endif
    @(posedge clk);
`ifdef MDU_CTRL_STALL_CNT_EN
    if (!rn) m_stall_cnt = 0;
    else if (e_stall) m_stall_cnt = m_stall_cnt + 1;
`endif
    if (!rn) begin
      m_cnt = 0; m_kind = 0;
    end else if (m_cnt > 0) begin
      m_cnt--;
      if (m_cnt == 0) m_kind = 0;
    end else if (e_start) begin
      m_cnt  = (op <= 3'd2) ? MUL_LAT : DIV_LAT;
      m_kind = (op <= 3'd2) ? 1 : 2;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
  endtask

  initial begin
    n_checks = 0; n_errors = 0;
    m_cnt = 0; m_kind = 0;
`ifdef MDU_CTRL_STALL_CNT_EN
    m_stall_cnt = 0;
`endif
    rst_n = 1'b0; issue_valid = 1'b0; issue_op = 3'd0; issue_mf = 1'b0; flush = 1'b0;
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    idle(1);

    // mult, then watch the busy window drain
    step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b1);
    idle(7);

    // div immediately followed by a held mflo
    step(1'b1, MDU_DIV, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 11; i++) step(1'b1, MDU_NONE, 1'b1, 1'b0, 1'b1);
    idle(2);

    // flushed mult, then re-presented
    step(1'b1, MDU_MULT, 1'b0, 1'b1, 1'b1);
    step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b1);
    idle(6);

    // div in flight with a flush arriving at cycle 4 alongside a stalled request
    step(1'b1, MDU_DIVU, 1'b0, 1'b0, 1'b1);
    idle(3);
    step(1'b1, MDU_MULTU, 1'b0, 1'b1, 1'b1);
    step(1'b1, MDU_MTLO, 1'b0, 1'b1, 1'b1);
    step(1'b1, MDU_NONE, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, MDU_MULTU, 1'b0, 1'b0, 1'b1);
    idle(6);

    // mthi and the reserved opcode in IDLE
    step(1'b1, MDU_MTHI, 1'b0, 1'b0, 1'b1);
    step(1'b1, MDU_RSVD, 1'b0, 1'b0, 1'b1);
    idle(1);

    // back-to-back mults
    step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, MDU_MULT, 1'b0, 1'b0, 1'b1);
    idle(6);

    // reset in cycle 3 of a divu with a stalled mfhi
    step(1'b1, MDU_DIVU, 1'b0, 1'b0, 1'b1);
    step(1'b1, MDU_NONE, 1'b1, 1'b0, 1'b1);
    step(1'b1, MDU_NONE, 1'b1, 1'b0, 1'b1);
    step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
    step(1'b1, MDU_NONE, 1'b1, 1'b0, 1'b1);
    idle(2);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0)
        step(1'b0, 3'd0, 1'b0, 1'b0, 1'b0);
      else
        step(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 4) == 0), 1'b1);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
